mult_soma_seq: RTL and testbench

- Parametrised sequential multiplier by repeated addition. Integrates the control FSM (set/rac/dec/cac/pronto style) and the accumulator/counter datapath in one block.
- Generalised in operand width, with:
  - optional operand swap, so the loop runs min(a,b) times;
  - accumulate (MAC) mode;
  - overflow flag;
  - cancel;
  - a one-cycle result-valid strobe.
- Sits under the top-level arithmetic unit as its multiply engine.

---
 rtl/mult_soma_seq.sv | 113 +++++++++++
 tb/tb_mult_soma_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_soma_seq.sv
// rtl/mult_soma_seq.sv - sequential multiplier by repeated addition with MAC, overflow and cancel
module mult_soma_seq #(
    parameter int WIDTH = 8,
    parameter bit TROCA = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               acumula,
    input  logic               cancela,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] produto,
    output logic               pronto,
    output logic               valido,
    output logic               estouro
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        SOMA   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] contador_q, contador_d;
    logic [WIDTH-1:0] mult_q, mult_d;
    logic [PW-1:0]    produto_q, produto_d;
    logic             estouro_q, estouro_d;

    // One extra bit so the carry out of the accumulator is visible.
    logic [PW:0]      soma;

    // Zero-extended accumulate of the multiplicand onto the current product.
    always_comb begin
        soma = {1'b0, produto_q} + {{(PW - WIDTH + 1){1'b0}}, mult_q};
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= OCIOSO;
            contador_q <= '0;
            mult_q     <= '0;
            produto_q  <= '0;
            estouro_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
            mult_q     <= mult_d;
            produto_q  <= produto_d;
            estouro_q  <= estouro_d;
        end
    end

    // Next-state and datapath control: accept in OCIOSO, iterate in SOMA, strobe in FIM.
    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        mult_d     = mult_q;
        produto_d  = produto_q;
        estouro_d  = estouro_q;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    estado_d  = SOMA;
                    estouro_d = 1'b0;
                    if (!acumula) begin
                        produto_d = '0;
                    end
                    // Counting the smaller operand minimises the number of additions.
                    if (TROCA && (b > a)) begin
                        contador_d = a;
                        mult_d     = b;
                    end else if (TROCA) begin
                        contador_d = b;
                        mult_d     = a;
                    end else begin
                        contador_d = b;
                        mult_d     = a;
                    end
                end
            end
            SOMA: begin
                if (cancela) begin
                    estado_d  = OCIOSO;
                    produto_d = '0;
                    estouro_d = 1'b0;
                end else if (contador_q == '0) begin
                    estado_d = FIM;
                end else begin
                    produto_d  = soma[PW-1:0];
                    contador_d = contador_q - WIDTH'(1);
                    estouro_d  = estouro_q | soma[PW];
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign produto = produto_q;
    assign pronto  = (estado_q == OCIOSO);
    assign valido  = (estado_q == FIM);
    assign estouro = estouro_q;

endmodule

// File: tb/tb_mult_soma_seq.sv
// tb/tb_mult_soma_seq.sv - directed self-checking bench for mult_soma_seq
module tb_mult_soma_seq;

    logic        clk;
    logic        rst;
    logic [3:0]  start_v;
    logic        acumula;
    logic        cancela;
    logic [15:0] a;
    logic [15:0] b;

    logic [15:0] p8t, p8n;
    logic [7:0]  p4;
    logic [31:0] p16;
    logic [3:0]  pronto_v, valido_v, estouro_v;

    int sel;
    logic [31:0] m_prod;
    logic        m_pronto, m_valido, m_estouro;

    int vectors;
    int miscompares;

    // DUT 0: WIDTH=8 TROCA=1
    mult_soma_seq #(.WIDTH(8), .TROCA(1'b1)) u_w8_t1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .acumula(acumula), .cancela(cancela),
        .a(a[7:0]), .b(b[7:0]), .produto(p8t), .pronto(pronto_v[0]),
        .valido(valido_v[0]), .estouro(estouro_v[0]));

    // DUT 1: WIDTH=8 TROCA=0
    mult_soma_seq #(.WIDTH(8), .TROCA(1'b0)) u_w8_t0 (
        .clk(clk), .rst(rst), .start(start_v[1]), .acumula(acumula), .cancela(cancela),
        .a(a[7:0]), .b(b[7:0]), .produto(p8n), .pronto(pronto_v[1]),
        .valido(valido_v[1]), .estouro(estouro_v[1]));

    // DUT 2: WIDTH=4 TROCA=1
    mult_soma_seq #(.WIDTH(4), .TROCA(1'b1)) u_w4_t1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .acumula(acumula), .cancela(cancela),
        .a(a[3:0]), .b(b[3:0]), .produto(p4), .pronto(pronto_v[2]),
        .valido(valido_v[2]), .estouro(estouro_v[2]));

    // DUT 3: WIDTH=16 TROCA=1
    mult_soma_seq #(.WIDTH(16), .TROCA(1'b1)) u_w16_t1 (
        .clk(clk), .rst(rst), .start(start_v[3]), .acumula(acumula), .cancela(cancela),
        .a(a), .b(b), .produto(p16), .pronto(pronto_v[3]),
        .valido(valido_v[3]), .estouro(estouro_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1:       m_prod = {16'd0, p8n};
            2:       m_prod = {24'd0, p4};
            3:       m_prod = p16;
            default: m_prod = {16'd0, p8t};
        endcase
        m_pronto  = pronto_v[sel[1:0]];
        m_valido  = valido_v[sel[1:0]];
        m_estouro = estouro_v[sel[1:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start one operation on DUT s and check latency, result, overflow and return to idle.
    // With noise=1 start stays high for the whole SOMA/FIM phase and must be ignored.
    task automatic run(input int s, input logic [15:0] av, input logic [15:0] bv,
                       input logic acc, input bit noise, input int exp_cyc,
                       input logic [31:0] exp_prod, input logic exp_est, input string tag);
        int n;
        @(negedge clk);
        sel = s;
        a = av;
        b = bv;
        acumula = acc;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = noise;
        n = 1;
        while (!m_valido && n < 1000) begin
            @(negedge clk);
            n++;
        end
        start_v[s] = 1'b0;
        chk({tag, "_cyc"}, n, exp_cyc);
        chk({tag, "_prod"}, m_prod, exp_prod);
        chk({tag, "_est"}, {31'd0, m_estouro}, {31'd0, exp_est});
        chk({tag, "_pronto_in_fim"}, {31'd0, m_pronto}, 32'd0);
        @(negedge clk);
        chk({tag, "_pronto_after"}, {31'd0, m_pronto}, 32'd1);
        chk({tag, "_valido_after"}, {31'd0, m_valido}, 32'd0);
        @(negedge clk);
        chk({tag, "_still_idle"}, {31'd0, m_pronto & ~m_valido}, 32'd1);
        chk({tag, "_prod_hold"}, m_prod, exp_prod);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        sel = 0;
        rst = 1'b0;
        start_v = 4'b0;
        acumula = 1'b0;
        cancela = 1'b0;
        a = 16'd0;
        b = 16'd0;

        // reset values
        #12;
        chk("rst_prod", m_prod, 32'd0);
        chk("rst_pronto", {31'd0, m_pronto}, 32'd1);
        chk("rst_valido", {31'd0, m_valido}, 32'd0);
        chk("rst_est", {31'd0, m_estouro}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // asynchronous reset mid-SOMA, 200*100 loads contador=100
        a = 16'd200;
        b = 16'd100;
        acumula = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_prod", m_prod, 32'd400);
        chk("pre_rst_pronto", {31'd0, m_pronto}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_prod", m_prod, 32'd0);
        chk("async_rst_pronto", {31'd0, m_pronto}, 32'd1);
        chk("async_rst_valido", {31'd0, m_valido}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {31'd0, m_pronto & ~m_valido}, 32'd1);
        chk("post_rst_prod", m_prod, 32'd0);

        // operand swap
        run(0, 16'd3, 16'd250, 1'b0, 1'b0, 5, 32'd750, 1'b0, "troca1_3x250");
        run(0, 16'd250, 16'd3, 1'b0, 1'b0, 5, 32'd750, 1'b0, "troca1_250x3");

        // no swap
        run(1, 16'd3, 16'd250, 1'b0, 1'b0, 252, 32'd750, 1'b0, "troca0_3x250");
        run(1, 16'd0, 16'd0, 1'b0, 1'b0, 2, 32'd0, 1'b0, "troca0_0x0");

        // MAC chain with wrap-around
        run(0, 16'd255, 16'd255, 1'b0, 1'b0, 257, 32'd65025, 1'b0, "mac_255x255");
        run(0, 16'd2, 16'd1, 1'b1, 1'b0, 3, 32'd65027, 1'b0, "mac_acc_2x1");
        run(0, 16'd255, 16'd2, 1'b1, 1'b0, 4, 32'd1, 1'b1, "mac_wrap");
        run(0, 16'd4, 16'd5, 1'b0, 1'b0, 6, 32'd20, 1'b0, "mac_clear");
        run(0, 16'd0, 16'd9, 1'b1, 1'b0, 2, 32'd20, 1'b0, "mac_acc_zero");

        // cancela while idle has no effect
        @(negedge clk);
        sel = 0;
        cancela = 1'b1;
        repeat (3) @(negedge clk);
        cancela = 1'b0;
        chk("idle_cancel_prod", m_prod, 32'd20);
        chk("idle_cancel_pronto", {31'd0, m_pronto}, 32'd1);
        chk("idle_cancel_valido", {31'd0, m_valido}, 32'd0);

        // start held through SOMA and FIM is ignored
        run(0, 16'd6, 16'd7, 1'b0, 1'b1, 8, 32'd42, 1'b0, "start_noise");

        // cancela on the second SOMA cycle of 10*20
        @(negedge clk);
        sel = 0;
        a = 16'd10;
        b = 16'd20;
        acumula = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("cancel_pre_prod", m_prod, 32'd20);
        cancela = 1'b1;
        @(negedge clk);
        cancela = 1'b0;
        chk("cancel_pronto", {31'd0, m_pronto}, 32'd1);
        chk("cancel_prod", m_prod, 32'd0);
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                if (m_valido) seen++;
                @(negedge clk);
            end
            chk("cancel_no_valido", seen, 32'd0);
        end

        // other widths
        run(2, 16'd15, 16'd15, 1'b0, 1'b0, 17, 32'd225, 1'b0, "w4_15x15");
        run(3, 16'd1, 16'd65535, 1'b0, 1'b0, 3, 32'd65535, 1'b0, "w16_1x65535");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
